// File: rtl/aes_key_sched_iter.sv
// rtl/aes_key_sched_iter.sv - iterative AES-128/192/256 key scheduler streaming round keys
module aes_key_sched_iter #(
    parameter int EN_192 = 1,
    parameter int EN_256 = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   key_len,
    input  logic [255:0] key,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_idx,
    output logic         done,
    output logic         err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GEN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [255:0]       key_q, key_d;
    logic [1:0]         len_q, len_d;
    logic [5:0]         i_q, i_d;
    logic [2:0]         j_q, j_d;
    logic [7:0]         rcon_q, rcon_d;
    logic [7:0][31:0]   win_q, win_d;
    logic [95:0]        acc_q, acc_d;
    logic [127:0]       rk_data_q, rk_data_d;
    logic [3:0]         rk_idx_q, rk_idx_d;
    logic               rk_valid_q, rk_valid_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [2:0]         nk_m1;
    logic [5:0]         last_i;
    logic [255:0]       key_sh;
    logic [31:0]        key_word;
    logic [31:0]        t_prev;
    logic [31:0]        w_old;
    logic [31:0]        sub_in;
    logic [31:0]        sub_out;
    logic [31:0]        w_new;
    logic               stall;
    logic               advance;
    logic               handshake;
    logic               len_bad;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) begin
                p = p ^ aa;
            end
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254, zero maps to zero) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Per-length constants and the next schedule word from the sliding window
    always_comb begin
        nk_m1   = 3'd3;
        last_i  = 6'd43;
        case (len_q)
            2'd1:    begin nk_m1 = 3'd5; last_i = 6'd51; end
            2'd2:    begin nk_m1 = 3'd7; last_i = 6'd59; end
            default: begin nk_m1 = 3'd3; last_i = 6'd43; end
        endcase

        key_sh   = key_q << {i_q[2:0], 5'd0};
        key_word = key_sh[255:224];
        t_prev   = win_q[0];
        w_old    = win_q[nk_m1];
        sub_in   = (j_q == 3'd0) ? {t_prev[23:0], t_prev[31:24]} : t_prev;
        sub_out  = {sbox(sub_in[31:24]), sbox(sub_in[23:16]),
                    sbox(sub_in[15:8]),  sbox(sub_in[7:0])};

        if (i_q <= {3'd0, nk_m1}) begin
            w_new = key_word;
        end else if (j_q == 3'd0) begin
            w_new = w_old ^ sub_out ^ {rcon_q, 24'h0};
        end else if ((len_q == 2'd2) && (j_q == 3'd4)) begin
            w_new = w_old ^ sub_out;
        end else begin
            w_new = w_old ^ t_prev;
        end

        len_bad   = (key_len == 2'd3) ||
                    ((key_len == 2'd1) && (EN_192 == 0)) ||
                    ((key_len == 2'd2) && (EN_256 == 0));
        handshake = rk_valid_q && rk_ready;
        // the word completing a round key may only load when the output slot is free
        stall     = (i_q[1:0] == 2'd3) && rk_valid_q && !rk_ready;
        advance   = (state_q == GEN) && !stall;
    end

    // Next-state, word counter, window/accumulator and output register updates
    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        len_d      = len_q;
        i_d        = i_q;
        j_d        = j_q;
        rcon_d     = rcon_q;
        win_d      = win_q;
        acc_d      = acc_q;
        rk_data_d  = rk_data_q;
        rk_idx_d   = rk_idx_q;
        rk_valid_d = rk_valid_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        if (handshake) begin
            rk_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len_bad) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = GEN;
                        key_d   = key;
                        len_d   = key_len;
                        i_d     = 6'd0;
                        j_d     = 3'd0;
                        rcon_d  = 8'h01;
                    end
                end
            end
            GEN: begin
                if (advance) begin
                    win_d = {win_q[6:0], w_new};
                    i_d   = i_q + 6'd1;
                    j_d   = (j_q == nk_m1) ? 3'd0 : j_q + 3'd1;
                    if ((i_q > {3'd0, nk_m1}) && (j_q == 3'd0)) begin
                        rcon_d = xtime(rcon_q);
                    end
                    case (i_q[1:0])
                        2'd0: acc_d[95:64] = w_new;
                        2'd1: acc_d[63:32] = w_new;
                        2'd2: acc_d[31:0]  = w_new;
                        default: begin
                            rk_data_d  = {acc_q, w_new};
                            rk_idx_d   = i_q[5:2];
                            rk_valid_d = 1'b1;
                        end
                    endcase
                    if (i_q == last_i) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (handshake) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            key_q      <= '0;
            len_q      <= 2'd0;
            i_q        <= 6'd0;
            j_q        <= 3'd0;
            rcon_q     <= 8'h01;
            win_q      <= '0;
            acc_q      <= '0;
            rk_data_q  <= '0;
            rk_idx_q   <= 4'd0;
            rk_valid_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            len_q      <= len_d;
            i_q        <= i_d;
            j_q        <= j_d;
            rcon_q     <= rcon_d;
            win_q      <= win_d;
            acc_q      <= acc_d;
            rk_data_q  <= rk_data_d;
            rk_idx_q   <= rk_idx_d;
            rk_valid_q <= rk_valid_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign rk_valid = rk_valid_q;
    assign rk_data  = rk_data_q;
    assign rk_idx   = rk_idx_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_aes_key_sched_iter.sv
// tb/tb_aes_key_sched_iter.sv - directed self-checking bench for aes_key_sched_iter
module tb_aes_key_sched_iter;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   key_len;
    logic [255:0] key;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_data;
    logic [3:0]   rk_idx;
    logic         done;
    logic         err;

    logic         start_n;
    logic [1:0]   key_len_n;
    logic [255:0] key_n;
    logic         busy_n;
    logic         rk_valid_n;
    logic         rk_ready_n;
    logic [127:0] rk_data_n;
    logic [3:0]   rk_idx_n;
    logic         done_n;
    logic         err_n;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [127:0] got_key [0:15];
    int           got_idx [0:15];
    int           got_cyc [0:15];
    int           n_got;
    int           done_cyc;
    int           n_err;
    int           acc_cyc;
    logic [127:0] exp128  [0:10];
    logic [127:0] ref256  [0:15];

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    aes_key_sched_iter dut (
        .clk(clk), .rst(rst), .start(start), .key_len(key_len), .key(key),
        .busy(busy), .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data),
        .rk_idx(rk_idx), .done(done), .err(err)
    );

    aes_key_sched_iter #(.EN_192(1), .EN_256(0)) dut_n (
        .clk(clk), .rst(rst), .start(start_n), .key_len(key_len_n), .key(key_n),
        .busy(busy_n), .rk_valid(rk_valid_n), .rk_ready(rk_ready_n), .rk_data(rk_data_n),
        .rk_idx(rk_idx_n), .done(done_n), .err(err_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a start for one cycle, then scramble key/key_len to show they are ignored
    task automatic start_sched(input logic [1:0] len, input logic [255:0] k);
        start   = 1'b1;
        key_len = len;
        key     = k;
        step();
        start   = 1'b0;
        key_len = 2'd0;
        key     = ~k;
        acc_cyc = cyc;
        chk("busy_after_start", 128'(busy), 128'd1);
    endtask

    // Consume keys with rk_ready high pct% of the time; optionally poke start while busy
    task automatic collect(input int pct, input int max_cyc, input bit inj);
        bit           held;
        logic [127:0] hd;
        logic [3:0]   hi;
        n_got    = 0;
        done_cyc = -1;
        n_err    = 0;
        held     = 1'b0;
        hd       = '0;
        hi       = '0;
        for (int c = 0; c < max_cyc; c++) begin
            rk_ready = ($urandom_range(99) < pct);
            if (inj && c == 3) begin
                start   = 1'b1;
                key_len = 2'd3;
                key     = '0;
            end else if (inj && c == 4) begin
                start   = 1'b0;
            end
            #1;
            if (err) n_err++;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (held) begin
                chk("hold_valid", 128'(rk_valid), 128'd1);
                chk("hold_data", rk_data, hd);
                chk("hold_idx", 128'(rk_idx), 128'(hi));
            end
            held = 1'b0;
            if (rk_valid && rk_ready) begin
                if (n_got < 16) begin
                    got_key[n_got] = rk_data;
                    got_idx[n_got] = int'(rk_idx);
                    got_cyc[n_got] = cyc;
                end
                n_got++;
            end else if (rk_valid) begin
                held = 1'b1;
                hd   = rk_data;
                hi   = rk_idx;
            end
            step();
        end
        rk_ready = 1'b1;
    endtask

    task automatic check_seq128(input string tag);
        chk({tag, "_count"}, 128'(n_got), 128'd11);
        for (int r = 0; r < 11 && r < n_got; r++) begin
            chk({tag, "_idx"}, 128'(got_idx[r]), 128'(r));
            chk({tag, "_key"}, got_key[r], exp128[r]);
        end
        chk({tag, "_done"}, 128'(done_cyc), 128'(got_cyc[10] + 1));
        chk({tag, "_busy_at_done"}, 128'(busy), 128'd0);
    endtask

    initial begin
        exp128[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        exp128[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        exp128[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        exp128[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        exp128[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        exp128[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        exp128[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        exp128[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        exp128[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        exp128[9]  = 128'hac7766f319fadc2128d12941575c006e;
        exp128[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        rst        = 1'b1;
        start      = 1'b0;
        key_len    = 2'd0;
        key        = '0;
        rk_ready   = 1'b1;
        start_n    = 1'b0;
        key_len_n  = 2'd0;
        key_n      = '0;
        rk_ready_n = 1'b1;
        repeat (3) step();

        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_valid", 128'(rk_valid), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        chk("rst_err", 128'(err), 128'd0);
        chk("rst_data", rk_data, 128'd0);
        chk("rst_idx", 128'(rk_idx), 128'd0);
        rst = 1'b0;
        step();

        // rejected starts: reserved length, and AES-256 on a build without it
        start     = 1'b1;
        key_len   = 2'd3;
        start_n   = 1'b1;
        key_len_n = 2'd2;
        key_n     = K256;
        step();
        start   = 1'b0;
        start_n = 1'b0;
        chk("rej3_err", 128'(err), 128'd1);
        chk("rej3_busy", 128'(busy), 128'd0);
        chk("rej256_err", 128'(err_n), 128'd1);
        chk("rej256_busy", 128'(busy_n), 128'd0);
        step();
        chk("rej3_err_pulse", 128'(err), 128'd0);
        chk("rej256_err_pulse", 128'(err_n), 128'd0);

        // AES-128 with ready high, plus a start poked while busy
        start_sched(2'd0, K128);
        collect(100, 200, 1'b1);
        check_seq128("a128");
        chk("a128_first_lat", 128'(got_cyc[0] - acc_cyc), 128'd4);
        for (int r = 1; r < 11; r++) begin
            chk("a128_spacing", 128'(got_cyc[r] - got_cyc[r-1]), 128'd4);
        end
        chk("busy_start_no_err", 128'(n_err), 128'd0);

        // AES-192 started in the done cycle of the previous schedule
        start_sched(2'd1, K192);
        collect(100, 200, 1'b0);
        chk("a192_count", 128'(n_got), 128'd13);
        for (int r = 0; r < 13 && r < n_got; r++) begin
            chk("a192_idx", 128'(got_idx[r]), 128'(r));
        end
        chk("a192_r0", got_key[0], K192[255:128]);
        chk("a192_r1", got_key[1], 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
        chk("a192_r12", got_key[12], 128'he98ba06f448c773c8ecc720401002202);
        chk("a192_done", 128'(done_cyc), 128'(got_cyc[12] + 1));

        // AES-256 with ready high
        start_sched(2'd2, K256);
        collect(100, 200, 1'b0);
        chk("a256_count", 128'(n_got), 128'd15);
        for (int r = 0; r < 15; r++) ref256[r] = got_key[r];
        chk("a256_r0", got_key[0], K256[255:128]);
        chk("a256_r1", got_key[1], 128'h1f352c073b6108d72d9810a30914dff4);
        chk("a256_r14", got_key[14], 128'hfe4890d1e6188d0b046df344706c631e);

        // AES-256 with random back-pressure
        start_sched(2'd2, K256);
        collect(30, 2000, 1'b0);
        chk("bp_count", 128'(n_got), 128'd15);
        for (int r = 0; r < 15 && r < n_got; r++) begin
            chk("bp_idx", 128'(got_idx[r]), 128'(r));
            chk("bp_key", got_key[r], ref256[r]);
        end
        chk("bp_r1", got_key[1], 128'h1f352c073b6108d72d9810a30914dff4);
        chk("bp_r14", got_key[14], 128'hfe4890d1e6188d0b046df344706c631e);
        chk("bp_done_seen", 128'(done_cyc > 0), 128'd1);

        // reset while round 5 of AES-128 is presented
        start_sched(2'd0, K128);
        begin
            bit found;
            found = 1'b0;
            for (int c = 0; c < 100; c++) begin
                #1;
                if (rk_valid && rk_idx == 4'd5) begin
                    found = 1'b1;
                    break;
                end
                step();
            end
            chk("mid_round5_reached", 128'(found), 128'd1);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_valid", 128'(rk_valid), 128'd0);
        chk("mid_rst_busy", 128'(busy), 128'd0);
        chk("mid_rst_idx", 128'(rk_idx), 128'd0);
        step();
        start_sched(2'd0, K128);
        collect(100, 200, 1'b0);
        check_seq128("rerun128");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
